// File: rtl/movimento_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// movimento_ctrl_pkg
// Shared definitions for the Freeway chicken movement controller and the
// downstream position stage: button direction codes, controller state
// encoding and the screen limits the position counter clamps against.
// -----------------------------------------------------------------------------
package movimento_ctrl_pkg;

  typedef logic [3:0] dir_t;

  // Raw button codes delivered by the board's direction pad.
  localparam dir_t DIR_FRENTE = 4'b0011;  // column + 1
  localparam dir_t DIR_BAIXO  = 4'b1100;  // row + 1
  localparam dir_t DIR_TRAS   = 4'b0001;  // column - 1
  localparam dir_t DIR_CIMA   = 4'b0100;  // row - 1

  // Screen limits, consumed by the position counter downstream.
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_KNOCK,
    ST_FROZEN
  } state_e;

  // True for the four codes that request motion; everything else is idle.
  function automatic logic dir_valid(input dir_t d);
    return (d == DIR_FRENTE) || (d == DIR_BAIXO) ||
           (d == DIR_TRAS)   || (d == DIR_CIMA);
  endfunction

endpackage

// File: rtl/movimento_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// movimento_ctrl_btn_debounce
// Two-flop synchronizer followed by a stability counter. A button code is
// accepted into dir_q only after it has been seen unchanged for DEB_CYCLES
// consecutive clocks, so short glitches never reach dir_q.
//
// Ports:
//   clk    system clock
//   nrst   asynchronous active-low reset
//   btn    raw asynchronous 4-bit button code
//   dir_q  debounced, synchronous button code
// -----------------------------------------------------------------------------
module movimento_ctrl_btn_debounce
  import movimento_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic nrst,
  input  dir_t btn,
  output dir_t dir_q
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  dir_t s1_q, s2_q, s3_q;  // s3_q holds s2 from the previous cycle
  dir_t dir_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    dir_d = dir_q;
    cnt_d = cnt_q;
    if (s2_q != s3_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      // Saturated and still unchanged this cycle: the code is stable. The
      // equality guard keeps a code that just changed from slipping through
      // while the counter is parked at its maximum.
      dir_d = s2_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      cnt_q <= '0;
      dir_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge; blocking ones would collapse the synchronizer chain.
      s1_q  <= btn;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

endmodule

// File: rtl/movimento_ctrl.sv
// -----------------------------------------------------------------------------
// movimento_ctrl
// Player chicken movement controller. Converts debounced direction buttons
// into rate-limited one-cycle step commands for the position counter, runs
// the collision knockback sequence and freezes everything while run is low.
//
// Ports:
//   clk            system clock (pixel clock domain)
//   nrst           asynchronous active-low reset
//   btn            raw asynchronous button code
//   hit            single-cycle collision pulse
//   run            1 = game running, 0 = frozen
//   column_en      one-cycle column step request
//   column_updown  1 = column + 1, 0 = column - 1 (held while column_en = 0)
//   row_en         one-cycle row step request
//   row_updown     1 = row + 1, 0 = row - 1 (held while row_en = 0)
//   knock          high while the knockback sequence is running
// -----------------------------------------------------------------------------
module movimento_ctrl
  import movimento_ctrl_pkg::*;
#(
  parameter int STEP_DIV    = 200000,
  parameter int DEB_CYCLES  = 50000,
  parameter int KNOCK_STEPS = 20
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] btn,
  input  logic       hit,
  input  logic       run,
  output logic       column_en,
  output logic       column_updown,
  output logic       row_en,
  output logic       row_updown,
  output logic       knock
);

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int KW = (KNOCK_STEPS > 0) ? $clog2(KNOCK_STEPS + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(STEP_DIV - 1);
  localparam logic [KW-1:0] KNOCK_MAX = KW'(KNOCK_STEPS);

  dir_t          dir_q;
  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [KW-1:0] knock_cnt_q, knock_cnt_d;
  logic          column_en_q, column_en_d, column_updown_q, column_updown_d;
  logic          row_en_q, row_en_d, row_updown_q, row_updown_d;
  logic          knock_q, knock_d;
  logic          tick;

  movimento_ctrl_btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .nrst  (nrst),
    .btn   (btn),
    .dir_q (dir_q)
  );

  always_comb begin
    tick            = (tick_cnt_q == TICK_MAX);
    tick_cnt_d      = tick ? '0 : tick_cnt_q + TW'(1);
    state_d         = state_q;
    knock_cnt_d     = knock_cnt_q;
    column_en_d     = 1'b0;
    row_en_d        = 1'b0;
    column_updown_d = column_updown_q;
    row_updown_d    = row_updown_q;

    if (!run) begin
      // Freeze beats everything except reset; the tick counter restarts from
      // zero so the first step after resuming is a full period away.
      state_d         = ST_FROZEN;
      tick_cnt_d      = '0;
      knock_cnt_d     = '0;
      column_updown_d = 1'b0;
      row_updown_d    = 1'b0;
    end else if (state_q == ST_FROZEN) begin
      state_d     = ST_IDLE;
      knock_cnt_d = '0;
    end else if (hit) begin
      // Entering or restarting knockback; a hit on a tick edge wins over the
      // step that tick would have produced.
      state_d     = ST_KNOCK;
      knock_cnt_d = KNOCK_MAX;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dir_valid(dir_q)) state_d = ST_MOVE;
        end
        ST_MOVE: begin
          if (!dir_valid(dir_q)) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            case (dir_q)
              DIR_FRENTE: begin column_en_d = 1'b1; column_updown_d = 1'b1; end
              DIR_TRAS:   begin column_en_d = 1'b1; column_updown_d = 1'b0; end
              DIR_BAIXO:  begin row_en_d    = 1'b1; row_updown_d    = 1'b1; end
              DIR_CIMA:   begin row_en_d    = 1'b1; row_updown_d    = 1'b0; end
              default: ;
            endcase
          end
        end
        ST_KNOCK: begin
          if (tick) begin
            row_en_d     = 1'b1;
            row_updown_d = 1'b1;
            knock_cnt_d  = knock_cnt_q - KW'(1);
            if (knock_cnt_q <= KW'(1)) begin
              state_d = dir_valid(dir_q) ? ST_MOVE : ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end

    knock_d = (state_d == ST_KNOCK);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q         <= ST_IDLE;
      tick_cnt_q      <= '0;
      knock_cnt_q     <= '0;
      column_en_q     <= 1'b0;
      column_updown_q <= 1'b0;
      row_en_q        <= 1'b0;
      row_updown_q    <= 1'b0;
      knock_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      knock_cnt_q     <= knock_cnt_d;
      column_en_q     <= column_en_d;
      column_updown_q <= column_updown_d;
      row_en_q        <= row_en_d;
      row_updown_q    <= row_updown_d;
      knock_q         <= knock_d;
    end
  end

  assign column_en     = column_en_q;
  assign column_updown = column_updown_q;
  assign row_en        = row_en_q;
  assign row_updown    = row_updown_q;
  assign knock         = knock_q;

endmodule

// File: tb/tb_movimento_ctrl.sv
// -----------------------------------------------------------------------------
// tb_movimento_ctrl
// Self-checking bench for movimento_ctrl with STEP_DIV=4, DEB_CYCLES=3,
// KNOCK_STEPS=2. Inputs are driven on the falling edge; the expected output
// word for the following rising edge is queued at the same time and compared
// 1 time unit after that rising edge.
//
// Edge c (c = 1, 2, ...) is the c-th rising edge after reset release. With a
// button held through reset, the debounced code lands on edge 6, the FSM
// enters MOVE on edge 7 and ticks occur on edges 4, 8, 12, ..., so the first
// step is visible after edge 8 and then every 4 edges.
// -----------------------------------------------------------------------------
module tb_movimento_ctrl;
  import movimento_ctrl_pkg::*;

  localparam int STEP_DIV    = 4;
  localparam int DEB_CYCLES  = 3;
  localparam int KNOCK_STEPS = 2;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       hit = 1'b0;
  logic       run = 1'b1;
  logic       column_en, column_updown, row_en, row_updown, knock;

  movimento_ctrl #(
    .STEP_DIV    (STEP_DIV),
    .DEB_CYCLES  (DEB_CYCLES),
    .KNOCK_STEPS (KNOCK_STEPS)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .btn           (btn),
    .hit           (hit),
    .run           (run),
    .column_en     (column_en),
    .column_updown (column_updown),
    .row_en        (row_en),
    .row_updown    (row_updown),
    .knock         (knock)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic col_en;
    logic col_ud;
    logic row_en;
    logic row_ud;
    logic knock;
  } out_t;

  typedef struct {
    out_t  o;
    string tag;
    int    c;
  } sb_t;

  typedef struct {
    logic [3:0] btn;
    int         ncyc;
    int         axis;  // 0 none, 1 column, 2 row
    logic       ud;
    string      name;
  } vec_t;

  sb_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic check(input string name, input int c, input logic [4:0] act,
                       input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s c=%0d: got %b expected %b (col_en col_ud row_en row_ud knock)",
               name, c, act, exp);
    end
  endtask

  // Scoreboard: one expected word per rising edge, compared just after it.
  always @(posedge clk) begin
    sb_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, e.c, {column_en, column_updown, row_en, row_updown, knock}, e.o);
    end
  end

  task automatic cyc(input logic n, input logic [3:0] b, input logic h,
                     input logic r, input out_t e, input string tag, input int c);
    @(negedge clk);
    nrst = n;
    btn  = b;
    hit  = h;
    run  = r;
    exp_q.push_back('{o: e, tag: tag, c: c});
  endtask

  // Three reset cycles with the button already pressed and hit toggling.
  task automatic do_reset(input logic [3:0] b);
    for (int i = 0; i < 3; i++) cyc(1'b0, b, i[0], 1'b1, '0, "reset", i);
  endtask

  function automatic out_t steady_exp(input int axis, input logic ud, input int c);
    out_t o;
    logic pulse, started;
    o       = '0;
    started = (c >= 8);
    pulse   = started && (c % 4 == 0);
    if (axis == 1) begin
      o.col_en = pulse;
      o.col_ud = started & ud;
    end else if (axis == 2) begin
      o.row_en = pulse;
      o.row_ud = started & ud;
    end
    return o;
  endfunction

  initial begin
    #20_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[6];
    out_t       e;
    logic [3:0] b;
    logic       h, r;

    tbl[0] = '{DIR_FRENTE, 40, 1, 1'b1, "hold_frente"};
    tbl[1] = '{DIR_CIMA,   40, 2, 1'b0, "hold_cima"};
    tbl[2] = '{DIR_BAIXO,  24, 2, 1'b1, "hold_baixo"};
    tbl[3] = '{DIR_TRAS,   24, 1, 1'b0, "hold_tras"};
    tbl[4] = '{4'b1111,    24, 0, 1'b0, "invalid_1111"};
    tbl[5] = '{4'b0000,    16, 0, 1'b0, "no_button"};

    #1 nrst = 1'b0;

    // Steady buttons from reset.
    foreach (tbl[k]) begin
      do_reset(tbl[k].btn);
      for (int c = 1; c <= tbl[k].ncyc; c++)
        cyc(1'b1, tbl[k].btn, 1'b0, 1'b1, steady_exp(tbl[k].axis, tbl[k].ud, c),
            tbl[k].name, c);
    end

    // Two-clock glitch of BAIXO never reaches the outputs; a held BAIXO from
    // edge 31 is accepted on edge 36 and steps on ticks 40, 44, 48.
    do_reset(4'b0000);
    for (int c = 1; c <= 50; c++) begin
      b = (c == 5 || c == 6 || c >= 31) ? DIR_BAIXO : 4'b0000;
      e = '0;
      e.row_en = (c == 40 || c == 44 || c == 48);
      e.row_ud = (c >= 40);
      cyc(1'b1, b, 1'b0, 1'b1, e, "glitch_then_baixo", c);
    end

    // Knockback: hit on edge 14, pulses on ticks 16 and 20, back to MOVE.
    do_reset(DIR_FRENTE);
    for (int c = 1; c <= 30; c++) begin
      h = (c == 14);
      e = '0;
      e.col_en = (c == 8 || c == 12 || c == 24 || c == 28);
      e.col_ud = (c >= 8);
      e.row_en = (c == 16 || c == 20);
      e.row_ud = (c >= 16);
      e.knock  = (c >= 14 && c <= 19);
      cyc(1'b1, DIR_FRENTE, h, 1'b1, e, "knockback", c);
    end

    // Re-hit on edge 18 after the first knock pulse: three pulses total.
    do_reset(DIR_FRENTE);
    for (int c = 1; c <= 30; c++) begin
      h = (c == 14 || c == 18);
      e = '0;
      e.col_en = (c == 8 || c == 12 || c == 28);
      e.col_ud = (c >= 8);
      e.row_en = (c == 16 || c == 20 || c == 24);
      e.row_ud = (c >= 16);
      e.knock  = (c >= 14 && c <= 23);
      cyc(1'b1, DIR_FRENTE, h, 1'b1, e, "re_hit", c);
    end

    // Freeze on edges 14..17; tick counter restarts so the next step is
    // edge 21, four clocks after run returns.
    do_reset(DIR_FRENTE);
    for (int c = 1; c <= 30; c++) begin
      r = !(c >= 14 && c <= 17);
      e = '0;
      e.col_en = (c == 8 || c == 12 || c == 21 || c == 25 || c == 29);
      e.col_ud = (c >= 8 && c <= 13) || (c >= 21);
      cyc(1'b1, DIR_FRENTE, 1'b0, r, e, "freeze", c);
    end

    // Reset asserted in the middle of a step pulse clears outputs at once.
    do_reset(DIR_FRENTE);
    for (int c = 1; c <= 8; c++)
      cyc(1'b1, DIR_FRENTE, 1'b0, 1'b1, steady_exp(1, 1'b1, c), "pre_async", c);
    @(posedge clk);
    #2;
    check("step_before_async_reset", 8,
          {column_en, column_updown, row_en, row_updown, knock}, 5'b11000);
    nrst = 1'b0;
    #1;
    check("async_reset_mid_step", 8,
          {column_en, column_updown, row_en, row_updown, knock}, 5'b00000);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 0, 5'(exp_q.size()), 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/movimento_ctrl.md
Name: movimento_ctrl

Overview:
Movement controller for the player chicken in the Freeway game, sitting directly upstream of the chicken position counter. Takes raw direction buttons and converts them into rate-limited single-cycle step commands: column_en/column_updown and row_en/row_updown. The commands advance the sprite one pixel per step. Also handles the collision knockback sequence and a global run/freeze gate.

Parameters:
STEP_DIV, 200000, clocks per movement tick; one step is allowed per tick.
DEB_CYCLES, 50000, consecutive stable clocks before a synchronized button code is accepted.
KNOCK_STEPS, 20, downward steps forced after a hit.

Ports:
clk  input  1  system clock (pixel clock domain)
nrst  input  1  asynchronous active-low reset
btn  input  4  raw, asynchronous button code: 4'b0011 FRENTE, 4'b1100 BAIXO, 4'b0001 TRAS, 4'b0100 CIMA; any other value = no motion
hit  input  1  single-cycle collision pulse, synchronous to clk
run  input  1  1 = game running; 0 = frozen
column_en  output  1  one-cycle step request, column axis
column_updown  output  1  1 = column+1 (right), 0 = column-1
row_en  output  1  one-cycle step request, row axis
row_updown  output  1  1 = row+1 (down screen), 0 = row-1
knock  output  1  high while in KNOCK state

Behaviour:
- Clocking and reset: single clock, reset asynchronous active-low.
- Reset values: all outputs 0; synchronizer flops 0; dir_q = 4'b0000; debounce count 0; tick count 0; state IDLE; knock counter 0.
- Input synchronizer: btn passes through a 2-flop synchronizer to give s2.
- Debounce:
  - A counter clears whenever s2 differs from its previous-cycle value; otherwise it increments, saturating at DEB_CYCLES-1.
  - On the edge where the counter equals DEB_CYCLES-1, dir_q <= s2.
  - Glitches shorter than DEB_CYCLES never reach dir_q.
- Tick:
  - Free-running counter 0..STEP_DIV-1.
  - tick is an internal signal, high when the count equals STEP_DIV-1; the counter wraps to 0 on the next edge.
  - While run=0 the counter is held at 0.
- States:
  - FROZEN: entered whenever run=0, from any state. Outputs 0. On run=1, go to IDLE with knock counter cleared.
  - IDLE: dir_q is not one of the four codes. No steps. Go to MOVE when dir_q becomes a valid code.
  - MOVE: on each tick emit exactly one step per the dir_q mapping:
    - FRENTE: column_en=1, column_updown=1.
    - TRAS: column_en=1, column_updown=0.
    - BAIXO: row_en=1, row_updown=1.
    - CIMA: row_en=1, row_updown=0.
    - Return to IDLE when dir_q becomes invalid.
  - KNOCK: entered on hit=1 when run=1, from IDLE or MOVE.
    - Loads knock counter = KNOCK_STEPS.
    - On each tick: emit row_en=1, row_updown=1 and decrement.
    - When the counter reaches 0, go to MOVE if dir_q is valid, else IDLE.
    - Buttons are ignored in KNOCK.
    - hit during KNOCK reloads the counter to KNOCK_STEPS.
- Priority per edge: nrst > run=0 > hit > tick step.
- Output timing:
  - Outputs are registered.
  - A step decided on the tick edge is visible for exactly one clock, starting the cycle after tick.
  - column_en and row_en are never high in the same cycle.
  - The updown outputs hold their last value when the corresponding en is 0.
- Boundary clamping/wrapping is the downstream counter's job; this block is position-agnostic.
- Reset mid-step forces all outputs to 0 immediately (asynchronous).

Decomposition:
- Shared package/include holds:
  - Direction code constants DIR_FRENTE=4'b0011, DIR_BAIXO=4'b1100, DIR_TRAS=4'b0001, DIR_CIMA=4'b0100.
  - State encoding IDLE/MOVE/KNOCK/FROZEN.
  - Screen limits 640/480, for use by the downstream stage.
- One natural sub-module: btn_debounce (2-flop sync plus stability counter, parameter DEB_CYCLES, output dir_q), reusable for the second player's controller.

Test Plan:
(Bench parameters: STEP_DIV=4, DEB_CYCLES=3, KNOCK_STEPS=2, run=1 unless stated.)
1. Reset hold: nrst=0 with btn=0011 and hit toggling -> all outputs 0; release -> no step until the debounce period has elapsed, and none before the first tick.
2. Hold btn=0011 steady for 40 clocks -> column_en pulses exactly once per 4 clocks, each 1 cycle wide, column_updown=1, row_en never 1. Repeat with 0100 -> row_en pulses with row_updown=0.
3. Glitch: btn=1100 for 2 clocks then back to 0000 -> no row_en ever. btn=1100 held 3+ clocks past sync -> row_en pulses with row_updown=1. Invalid code 1111 -> no pulses.
4. Knockback: holding 0011, inject hit -> knock=1; exactly 2 row_en pulses with row_updown=1 and no column_en; then column_en pulses resume.
5. Re-hit: second hit after the first knock pulse -> total 3 knock pulses before exit.
6. Freeze: run=0 mid-MOVE -> outputs 0 within one clock and knock=0; run=1 -> first step occurs exactly 4 clocks later (tick counter was held at 0).
